// File: rtl/rs_adder_scheduler.sv
// rs_adder_scheduler: issue scheduler for the 8-row adder reservation station.
// Allocates free rows, tracks operand tags with CDB wakeup, dispatches the
// oldest ready row to a pipelined adder and reports completion by row tag.
//
// Ports:
//   Clock, Resetn            clock, asynchronous active-low reset
//   alloc_valid/qj/qk        decoded instruction and its operand producer tags
//   alloc_ready, alloc_idx   row availability and the lowest free row index
//   cdb_valid, cdb_tag       common-data-bus broadcast
//   issue_valid, issue_idx   oldest ready row offered to the adder
//   fu_ready                 adder accepts the offer this cycle
//   flush                    squash all rows and in-flight operations
//   done_valid, done_tag     completion pulse with the finishing row's tag
//   Busy                     per-row occupancy
module rs_adder_scheduler #(
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TAG_BASE = 1,
    parameter int unsigned ADD_LAT  = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             alloc_valid,
    input  logic [TAG_W-1:0] alloc_qj,
    input  logic [TAG_W-1:0] alloc_qk,
    output logic             alloc_ready,
    output logic [2:0]       alloc_idx,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             issue_valid,
    output logic [2:0]       issue_idx,
    input  logic             fu_ready,
    input  logic             flush,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic [7:0]       Busy
);

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = 3;

    // Row state
    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] exec_q, exec_d;
    logic [TAG_W-1:0]   qj_q [ENTRIES];
    logic [TAG_W-1:0]   qj_d [ENTRIES];
    logic [TAG_W-1:0]   qk_q [ENTRIES];
    logic [TAG_W-1:0]   qk_d [ENTRIES];
    // older_q[i][j] set means row j was allocated before row i
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] older_d [ENTRIES];

    // Adder latency pipe; the last stage is the completing operation
    logic [ADD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [IDX_W-1:0]   pipe_idx_q [ADD_LAT];
    logic [IDX_W-1:0]   pipe_idx_d [ADD_LAT];

    logic [ENTRIES-1:0] ready_c;
    logic [ENTRIES-1:0] oldest_c;
    logic [IDX_W-1:0]   done_idx_c;
    logic               alloc_fire_c;
    logic               issue_fire_c;

    assign Busy = busy_q;

    // Lowest free row
    always_comb begin
        alloc_ready = ~&busy_q;
        alloc_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // Oldest-ready select: a ready row with no older ready row
    always_comb begin
        ready_c  = '0;
        oldest_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            ready_c[i] = busy_q[i] & ~exec_q[i] & (qj_q[i] == '0) & (qk_q[i] == '0);
        end
        for (int i = 0; i < int'(ENTRIES); i++) begin
            oldest_c[i] = ready_c[i] & ~|(older_q[i] & ready_c);
        end
        issue_valid = |ready_c;
        issue_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (oldest_c[i]) issue_idx = IDX_W'(i);
        end
    end

    // Completion comes straight off the registered pipe tail
    always_comb begin
        done_valid = pipe_vld_q[ADD_LAT-1];
        done_idx_c = pipe_idx_q[ADD_LAT-1];
        done_tag   = done_valid ? (TAG_W'(TAG_BASE) + TAG_W'(done_idx_c)) : '0;
    end

    // Next-state: wakeup, alloc, issue, completion, then flush overrides all
    always_comb begin
        busy_d       = busy_q;
        exec_d       = exec_q;
        qj_d         = qj_q;
        qk_d         = qk_q;
        older_d      = older_q;
        pipe_vld_d   = pipe_vld_q;
        pipe_idx_d   = pipe_idx_q;
        alloc_fire_c = alloc_valid & alloc_ready;
        issue_fire_c = issue_valid & fu_ready;

        if (cdb_valid && (cdb_tag != '0)) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (busy_q[i] && (qj_q[i] == cdb_tag)) qj_d[i] = '0;
                if (busy_q[i] && (qk_q[i] == cdb_tag)) qk_d[i] = '0;
            end
        end

        // New row is younger than every row currently resident
        if (alloc_fire_c) begin
            busy_d[alloc_idx]  = 1'b1;
            exec_d[alloc_idx]  = 1'b0;
            qj_d[alloc_idx]    = (cdb_valid && (cdb_tag == alloc_qj)) ? '0 : alloc_qj;
            qk_d[alloc_idx]    = (cdb_valid && (cdb_tag == alloc_qk)) ? '0 : alloc_qk;
            older_d[alloc_idx] = busy_q;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_d[i][alloc_idx] = 1'b0;
            end
        end

        if (issue_fire_c) exec_d[issue_idx] = 1'b1;

        pipe_vld_d[0] = issue_fire_c;
        pipe_idx_d[0] = issue_idx;
        for (int s = 1; s < int'(ADD_LAT); s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_idx_d[s] = pipe_idx_q[s-1];
        end

        // Freed row drops out of the age ordering entirely
        if (done_valid) begin
            busy_d[done_idx_c]  = 1'b0;
            exec_d[done_idx_c]  = 1'b0;
            older_d[done_idx_c] = '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_d[i][done_idx_c] = 1'b0;
            end
        end

        if (flush) begin
            busy_d     = '0;
            exec_d     = '0;
            pipe_vld_d = '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_d[i] = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            busy_q     <= '0;
            exec_q     <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                older_q[i] <= '0;
            end
            for (int s = 0; s < int'(ADD_LAT); s++) begin
                pipe_idx_q[s] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            exec_q     <= exec_d;
            pipe_vld_q <= pipe_vld_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            older_q    <= older_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

endmodule

// File: tb/tb_rs_adder_scheduler.sv
module tb_rs_adder_scheduler;

    localparam int LAT = 2;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       alloc_valid = 1'b0;
    logic [3:0] alloc_qj = '0, alloc_qk = '0;
    logic       alloc_ready;
    logic [2:0] alloc_idx;
    logic       cdb_valid = 1'b0;
    logic [3:0] cdb_tag = '0;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic       fu_ready = 1'b0;
    logic       flush = 1'b0;
    logic       done_valid;
    logic [3:0] done_tag;
    logic [7:0] Busy;

    int n_checks = 0;
    int n_pass   = 0;

    rs_adder_scheduler #(.TAG_W(4), .TAG_BASE(1), .ADD_LAT(LAT)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .alloc_valid(alloc_valid), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_idx(issue_idx),
        .fu_ready(fu_ready), .flush(flush),
        .done_valid(done_valid), .done_tag(done_tag), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Reference model: rows with an allocation sequence number, and a
    // per-row countdown of edges until its result appears.
    bit m_busy [8];
    bit m_exec [8];
    int m_qj [8];
    int m_qk [8];
    int m_age [8];
    int m_rem [8];
    int m_age_ctr;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 0; m_exec[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
            m_age[i] = 0; m_rem[i] = -1;
        end
        m_age_ctr = 0;
    endfunction

    function automatic int exp_issue_row();
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (m_busy[i] && !m_exec[i] && m_qj[i] == 0 && m_qk[i] == 0)
                if (best < 0 || m_age[i] < m_age[best]) best = i;
        return best;
    endfunction

    function automatic int exp_free_row();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int exp_done_row();
        for (int i = 0; i < 8; i++) if (m_rem[i] == 0) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_busy();
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = m_busy[i];
        return b;
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        int iss = exp_issue_row();
        int fr  = exp_free_row();
        if (flush) begin
            for (int i = 0; i < 8; i++) begin
                m_busy[i] = 0; m_exec[i] = 0; m_rem[i] = -1;
            end
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_rem[i] == 0) begin
                m_busy[i] = 0; m_exec[i] = 0; m_rem[i] = -1;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
            end
        end
        if (cdb_valid && cdb_tag != 0)
            for (int i = 0; i < 8; i++)
                if (m_busy[i]) begin
                    if (m_qj[i] == int'(cdb_tag)) m_qj[i] = 0;
                    if (m_qk[i] == int'(cdb_tag)) m_qk[i] = 0;
                end
        if (alloc_valid && fr >= 0) begin
            m_busy[fr] = 1; m_exec[fr] = 0;
            m_qj[fr] = (cdb_valid && cdb_tag == alloc_qj) ? 0 : int'(alloc_qj);
            m_qk[fr] = (cdb_valid && cdb_tag == alloc_qk) ? 0 : int'(alloc_qk);
            m_age[fr] = m_age_ctr++;
        end
        if (iss >= 0 && fu_ready) begin
            m_exec[iss] = 1; m_rem[iss] = LAT - 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_qj = 0; alloc_qk = 0;
        cdb_valid = 0; cdb_tag = 0; fu_ready = 0; flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 Resetn = 0;
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        #2 Resetn = 1;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        @(negedge Clock);
        #2 Resetn = 1;
        @(negedge Clock);
        n_checks++; if (Busy !== 8'h00) $display("FAIL rst_busy got %h exp 00", Busy); else n_pass++;
        n_checks++; if (done_valid !== 1'b0) $display("FAIL rst_done_valid got %b exp 0", done_valid); else n_pass++;
        n_checks++; if (done_tag !== 4'd0) $display("FAIL rst_done_tag got %0d exp 0", done_tag); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid got %b exp 0", issue_valid); else n_pass++;
        n_checks++; if (issue_idx !== 3'd0) $display("FAIL rst_issue_idx got %0d exp 0", issue_idx); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready got %b exp 1", alloc_ready); else n_pass++;
        n_checks++; if (alloc_idx !== 3'd0) $display("FAIL rst_alloc_idx got %0d exp 0", alloc_idx); else n_pass++;
        // Mid-operation: rows 0-3 busy, rows 0 and 1 in flight
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1; alloc_qj = 0; alloc_qk = 0; fu_ready = (k >= 2);
            tick();
        end
        clear_inputs();
        n_checks++; if (Busy !== 8'h0F) $display("FAIL midrst_pre_busy got %h exp 0f", Busy); else n_pass++;
        n_checks++; if (done_valid !== 1'b1) $display("FAIL midrst_pre_done got %b exp 1", done_valid); else n_pass++;
        #2 Resetn = 0;
        model_reset();
        #1;
        n_checks++; if (Busy !== 8'h00) $display("FAIL midrst_busy got %h exp 00", Busy); else n_pass++;
        n_checks++; if (done_valid !== 1'b0) $display("FAIL midrst_done got %b exp 0", done_valid); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b1) $display("FAIL midrst_alloc_ready got %b exp 1", alloc_ready); else n_pass++;
        n_checks++; if (alloc_idx !== 3'd0) $display("FAIL midrst_alloc_idx got %0d exp 0", alloc_idx); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL midrst_issue_valid got %b exp 0", issue_valid); else n_pass++;
        @(posedge Clock);
        @(negedge Clock);
        #2 Resetn = 1;
        @(negedge Clock);
        n_checks++; if (done_valid !== 1'b0) $display("FAIL midrst_post_done got %b exp 0", done_valid); else n_pass++;
    endtask

    task automatic test_in_order();
        logic       iv [6];
        logic [2:0] ii [6];
        logic       dv [6];
        logic [3:0] dt [6];
        do_reset();
        for (int c = 0; c < 6; c++) begin
            iv[c] = issue_valid; ii[c] = issue_idx; dv[c] = done_valid; dt[c] = done_tag;
            alloc_valid = (c < 3); alloc_qj = 0; alloc_qk = 0; fu_ready = 1;
            tick();
        end
        clear_inputs();
        for (int c = 1; c < 4; c++) begin
            n_checks++; if (iv[c] !== 1'b1 || ii[c] !== 3'(c - 1))
                $display("FAIL inorder_issue c%0d got v%b idx%0d exp v1 idx%0d", c, iv[c], ii[c], c - 1); else n_pass++;
        end
        for (int c = 0; c < 6; c++) begin
            n_checks++; if (dv[c] !== (c >= 3) || (c >= 3 && dt[c] !== 4'(c - 2)))
                $display("FAIL inorder_done c%0d got v%b tag%0d exp v%0d tag%0d", c, dv[c], dt[c], c >= 3, c - 2); else n_pass++;
        end
        repeat (3) tick();
    endtask

    task automatic test_wakeup();
        // Younger ready row goes first; older row follows its broadcast
        do_reset();
        alloc_valid = 1; alloc_qj = 5; alloc_qk = 0; fu_ready = 1; tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_blocked got %b exp 0", issue_valid); else n_pass++;
        alloc_qj = 0; tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd1) $display("FAIL wake_first got v%b idx%0d exp v1 idx1", issue_valid, issue_idx); else n_pass++;
        alloc_valid = 0; cdb_valid = 1; cdb_tag = 5; tick();
        cdb_valid = 0;
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0) $display("FAIL wake_second got v%b idx%0d exp v1 idx0", issue_valid, issue_idx); else n_pass++;
        repeat (4) tick();
        // Held offer is preempted by an older row that becomes ready
        do_reset();
        alloc_valid = 1; alloc_qj = 5; alloc_qk = 0; fu_ready = 0; tick();
        alloc_qj = 0; tick();
        alloc_valid = 0;
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd1) $display("FAIL preempt_offer got v%b idx%0d exp v1 idx1", issue_valid, issue_idx); else n_pass++;
        cdb_valid = 1; cdb_tag = 5; tick();
        cdb_valid = 0;
        n_checks++; if (issue_idx !== 3'd0) $display("FAIL preempt_older got %0d exp 0", issue_idx); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0) $display("FAIL preempt_hold got v%b idx%0d exp v1 idx0", issue_valid, issue_idx); else n_pass++;
        fu_ready = 1; tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd1) $display("FAIL preempt_next got v%b idx%0d exp v1 idx1", issue_valid, issue_idx); else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            alloc_valid = 1; alloc_qj = 9; alloc_qk = 0; fu_ready = 1;
            tick();
        end
        alloc_valid = 0;
        n_checks++; if (Busy !== 8'hFF) $display("FAIL full_busy got %h exp ff", Busy); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_alloc_ready got %b exp 0", alloc_ready); else n_pass++;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL full_waiting got %b exp 0", issue_valid); else n_pass++;
        cdb_valid = 1; cdb_tag = 9; tick();
        cdb_valid = 0;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'(k))
                $display("FAIL full_order k%0d got v%b idx%0d exp v1 idx%0d", k, issue_valid, issue_idx, k); else n_pass++;
            if (k == 2) begin
                n_checks++; if (done_valid !== 1'b1 || done_tag !== 4'd1) $display("FAIL full_first_done got v%b tag%0d exp v1 tag1", done_valid, done_tag); else n_pass++;
                n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_still_full got %b exp 0", alloc_ready); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 3'd0) $display("FAIL full_freed got r%b idx%0d exp r1 idx0", alloc_ready, alloc_idx); else n_pass++;
            end
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_bypass();
        do_reset();
        alloc_valid = 1; alloc_qj = 0; alloc_qk = 6; cdb_valid = 1; cdb_tag = 6; fu_ready = 0; tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0) $display("FAIL bypass_qk got v%b idx%0d exp v1 idx0", issue_valid, issue_idx); else n_pass++;
        alloc_qj = 7; alloc_qk = 0; cdb_tag = 3; tick();
        alloc_valid = 0; cdb_valid = 0; fu_ready = 1; tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL bypass_nomatch got %b exp 0", issue_valid); else n_pass++;
        alloc_valid = 1; alloc_qj = 7; alloc_qk = 0; cdb_valid = 1; cdb_tag = 7; tick();
        alloc_valid = 0; cdb_valid = 0;
        n_checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd1) $display("FAIL bypass_qj got v%b idx%0d exp v1 idx1", issue_valid, issue_idx); else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_flush();
        bit seen;
        do_reset();
        fu_ready = 1;
        alloc_valid = 1; alloc_qj = 0; tick();
        tick();
        alloc_qj = 3; tick();
        alloc_valid = 0;
        n_checks++; if (done_valid !== 1'b1 || done_tag !== 4'd1) $display("FAIL flush_pre_done got v%b tag%0d exp v1 tag1", done_valid, done_tag); else n_pass++;
        flush = 1; tick();
        flush = 0;
        n_checks++; if (Busy !== 8'h00) $display("FAIL flush_busy got %h exp 00", Busy); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 3'd0) $display("FAIL flush_alloc got r%b idx%0d exp r1 idx0", alloc_ready, alloc_idx); else n_pass++;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_valid !== 1'b0) seen = 1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_done got pulse %b exp 0", seen); else n_pass++;
    endtask

    task automatic test_random();
        int er, ef, ed;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            er = exp_issue_row(); ef = exp_free_row(); ed = exp_done_row();
            n_checks++; if (Busy !== exp_busy()) $display("FAIL rnd_busy c%0d got %h exp %h", c, Busy, exp_busy()); else n_pass++;
            n_checks++; if (alloc_ready !== (ef >= 0)) $display("FAIL rnd_alloc_ready c%0d got %b exp %0d", c, alloc_ready, ef >= 0); else n_pass++;
            if (ef >= 0) begin
                n_checks++; if (alloc_idx !== 3'(ef)) $display("FAIL rnd_alloc_idx c%0d got %0d exp %0d", c, alloc_idx, ef); else n_pass++;
            end
            n_checks++; if (issue_valid !== (er >= 0)) $display("FAIL rnd_issue_valid c%0d got %b exp %0d", c, issue_valid, er >= 0); else n_pass++;
            if (er >= 0) begin
                n_checks++; if (issue_idx !== 3'(er)) $display("FAIL rnd_issue_idx c%0d got %0d exp %0d", c, issue_idx, er); else n_pass++;
            end
            n_checks++; if (done_valid !== (ed >= 0) || done_tag !== ((ed >= 0) ? 4'(ed + 1) : 4'd0))
                $display("FAIL rnd_done c%0d got v%b tag%0d exp row%0d", c, done_valid, done_tag, ed); else n_pass++;
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_qj    = ($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom_range(1, 6));
            alloc_qk    = ($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom_range(1, 6));
            cdb_valid   = ($urandom_range(0, 1) == 1);
            cdb_tag     = 4'($urandom_range(0, 6));
            fu_ready    = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wakeup();
        test_full();
        test_bypass();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
